sipo_collector: RTL and testbench
=================================

Name: sipo_collector

Overview:
- Serial-in, parallel-out collector: the receive end of the LSB-first serial stream produced by the multiplier's parallel-in/serial-out shifter.
- Accumulates WIDTH qualified serial bits into a parallel word, then presents it on a valid/ready output handshake.
- Sits at the multiplier output side; reassembles serial product or operand bits for the parallel host interface.

Parameters:
- WIDTH, 64, number of serial bits per word and width of the parallel output.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  arm/clear pulse; begins a new word collection.
- en  input  1  din qualifier; a bit is taken only when en=1 in COLLECT.
- din  input  1  serial data, LSB first.
- dout  output  WIDTH  assembled word; dout[i] = i-th accepted bit.
- out_valid  output  1  dout holds a complete word.
- out_ready  input  1  consumer accepts dout when out_valid=1.
- busy  output  1  high in COLLECT.
- overrun  output  1  sticky: start seen while out_valid=1 and not consumed.

Behaviour:
- Reset (rst=1 at a clk edge, highest priority, any state): state=IDLE, shift register=0, dout=0, bit count=0, out_valid=0, busy=0, overrun=0.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - start=1 -> COLLECT; clear shift register and bit count.
  - en and din are ignored.
- COLLECT:
  - On each edge with en=1: shift register <= {din, shreg[WIDTH-1:1]} (shift right, new bit enters the MSB); count increments.
  - After WIDTH accepted bits, first accepted bit is at [0] and last at [WIDTH-1].
  - On the edge accepting bit WIDTH: next state HOLD; dout loads the completed word including that bit; out_valid=1 from the next cycle. Latency is 1 cycle after the last bit.
  - en=0: hold state, count and register; no timeout.
  - start=1 in COLLECT: restart. Clear register and count, stay in COLLECT. A same-cycle en bit is discarded. start has priority over en.
- HOLD:
  - out_valid=1; dout stable.
  - out_ready=1 -> IDLE, out_valid=0 next cycle; dout retains its last value.
  - en ignored.
  - start=1 with out_ready=0: overrun<=1 (sticky until rst); start is otherwise ignored and state stays HOLD.
  - start=1 with out_ready=1 in the same cycle: transfer completes and the block goes directly to COLLECT, cleared. No overrun.
- busy = (state==COLLECT).
- dout changes only on entry to HOLD or on reset.
- Counter: saturates logic not needed; the count is compared to WIDTH, reset on start or leaving COLLECT.
- Pairing: shifter ld -> collector start in the same cycle. Assert en from the cycle after ld for WIDTH cycles, matching the shifter's one-cycle output latency.

Decomposition:
- Shared package spm_pkg:
  - state enum (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2);
  - default SPM_WIDTH=64 constant used by both shifter and collector.
- One natural sub-module: sipo_bit_counter. Has clear/inc inputs and a terminal-count output tc, asserted when count==WIDTH-1 and inc=1. The FSM and shift register stay in sipo_collector.

Test Plan:
- WIDTH=8: rst, start, then 8 cycles en=1 with din=1,0,1,1,0,0,1,0 -> out_valid=1 one cycle after the 8th bit, dout=8'h4D, busy=0.
- WIDTH=64: serialize 64'hDEADBEEF_01234567 LSB first with en gaps (en=0 every 3rd cycle) -> dout=64'hDEADBEEF01234567 exactly once; out_valid held until out_ready.
- WIDTH=8: after 5 bits, pulse start (en=1, din=1 same cycle), then send 8'hA5 -> dout=8'hA5; the pre-restart bits and the same-cycle din are discarded.
- HOLD with out_ready=0 for 10 cycles, start pulsed once -> overrun=1 and stays 1; dout unchanged; out_ready then -> IDLE, out_valid=0.
- HOLD with start and out_ready both 1 in one cycle -> out_valid=0 and busy=1 next cycle; overrun=0; the next 8 bits assemble correctly.
- rst asserted mid-COLLECT (bit 3) and in HOLD -> all outputs 0 next cycle; a subsequent start plus 8 bits of 8'h0F yields dout=8'h0F.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the serial multiplier datapath.
// Used by the PISO shifter and the SIPO collector.
package spm_pkg;

  localparam int SPM_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } spm_state_e;

endpackage

// File: rtl/sipo_bit_counter.sv
// Accepted-bit counter for the SIPO collector.
// tc flags the increment that completes a word.
module sipo_bit_counter #(
  parameter int WIDTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = inc && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// Serial-in parallel-out collector, LSB first,
// with valid/ready output and sticky overrun flag.
module sipo_collector
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  spm_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovr_q, ovr_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          shreg_d = '0;
          cnt_clr = 1'b1;
        end
      end
      COLLECT: begin
        // start wins over a same-cycle data bit
        if (start) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
        end else if (en) begin
          shreg_d = {din, shreg_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            dout_d  = shreg_d;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_d = COLLECT;
            shreg_d = '0;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == COLLECT);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector at WIDTH=8 and WIDTH=64.
module tb_sipo_collector;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        rst, start, en, din, out_ready;
  logic [7:0]  dout;
  logic        out_valid, busy, overrun;

  logic        rst_w, start_w, en_w, din_w, out_ready_w;
  logic [63:0] dout_w;
  logic        out_valid_w, busy_w, overrun_w;

  always #5 clk = ~clk;

  sipo_collector #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en        (en),
    .din       (din),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  sipo_collector #(.WIDTH(64)) dut64 (
    .clk       (clk),
    .rst       (rst_w),
    .start     (start_w),
    .en        (en_w),
    .din       (din_w),
    .dout      (dout_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .busy      (busy_w),
    .overrun   (overrun_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d,
                         input logic v, input logic b, input logic o);
    chk({tag, "_dout"}, 64'(dout), 64'(d));
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_busy"}, 64'(busy), 64'(b));
    chk({tag, "_ovr"}, 64'(overrun), 64'(o));
  endtask

  task automatic send8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      en  = 1'b1;
      din = v[i];
      tick();
      if (i == 6) chk("pre_last_valid", 64'(out_valid), 64'd0);
    end
    en  = 1'b0;
    din = 1'b0;
  endtask

  task automatic start8();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] word;
    int          idx;
    int          cyc;
    int          vcnt;

    rst = 1'b1; start = 1'b0; en = 1'b0; din = 1'b0; out_ready = 1'b0;
    rst_w = 1'b1; start_w = 1'b0; en_w = 1'b0; din_w = 1'b0;
    out_ready_w = 1'b0;
    tick();
    rst = 1'b0; rst_w = 1'b0;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset64_dout", dout_w, 64'd0);

    // basic 8-bit word 0x4D
    en = 1'b1; din = 1'b1;
    tick();
    en = 1'b0;
    chk_all("idle_ignores_en", 8'h00, 1'b0, 1'b0, 1'b0);
    start8();
    chk("start_busy", 64'(busy), 64'd1);
    send8(8'h4D);
    chk_all("word4d", 8'h4D, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_all("ack4d", 8'h4D, 1'b0, 1'b0, 1'b0);

    // restart after 5 bits, same-cycle bit discarded
    start8();
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; din = 1'b1;
      tick();
    end
    en = 1'b0;
    tick();
    chk("gap_hold_busy", 64'(busy), 64'd1);
    start = 1'b1; en = 1'b1; din = 1'b1;
    tick();
    start = 1'b0; en = 1'b0;
    chk_all("restart", 8'h4D, 1'b0, 1'b1, 1'b0);
    send8(8'hA5);
    chk_all("worda5", 8'hA5, 1'b1, 1'b0, 1'b0);

    // overrun in HOLD
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      en = 1'b1; din = 1'b0;
      tick();
    end
    start = 1'b0; en = 1'b0;
    chk_all("overrun", 8'hA5, 1'b1, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_all("ovr_ack", 8'hA5, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // start and ready together in HOLD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst2", 8'h00, 1'b0, 1'b0, 1'b0);
    start8();
    send8(8'h3C);
    chk_all("word3c", 8'h3C, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk_all("start_ready", 8'h3C, 1'b0, 1'b1, 1'b0);
    send8(8'h96);
    chk_all("word96", 8'h96, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset mid-collect and in HOLD
    start8();
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; din = 1'b1;
      tick();
    end
    en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_collect", 8'h00, 1'b0, 1'b0, 1'b0);
    start8();
    send8(8'hFF);
    chk("pre_rst_hold_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    start8();
    send8(8'h0F);
    chk_all("word0f", 8'h0F, 1'b1, 1'b0, 1'b0);

    // 64-bit word with en gaps
    word = 64'hDEADBEEF_01234567;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    chk("busy64", 64'(busy_w), 64'd1);
    idx = 0; cyc = 0; vcnt = 0;
    while (idx < 64 && cyc < 200) begin
      en_w  = (cyc % 3) != 2;
      din_w = word[idx];
      tick();
      if (en_w) idx++;
      if (out_valid_w) vcnt++;
      cyc++;
    end
    en_w = 1'b0; din_w = 1'b0;
    chk("bits64_sent", 64'(idx), 64'd64);
    chk("valid64_once", 64'(vcnt), 64'd1);
    chk("dout64", dout_w, word);
    for (int i = 0; i < 3; i++) begin
      en_w = 1'b1; din_w = 1'b1;
      tick();
    end
    en_w = 1'b0;
    chk("valid64_held", 64'(out_valid_w), 64'd1);
    chk("dout64_held", dout_w, word);
    out_ready_w = 1'b1;
    tick();
    out_ready_w = 1'b0;
    chk("ack64_valid", 64'(out_valid_w), 64'd0);
    chk("ack64_busy", 64'(busy_w), 64'd0);
    chk("ack64_dout", dout_w, word);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
